// File: rtl/tri_meas_if.sv
// Sample bus between the triangle-wave generator and tri_meas, plus the
// measurement results published back by tri_meas.
//   master : drives d_in/d_valid, observes results (generator side / bench)
//   slave  : tri_meas; consumes samples, drives results, strobes and debug state
interface tri_meas_if #(
    parameter int unsigned DW    = 9,
    parameter int unsigned CNT_W = 10
);
    logic [DW-1:0]    d_in;
    logic             d_valid;
    logic [CNT_W-1:0] rise_len;
    logic [CNT_W-1:0] top_len;
    logic [CNT_W-1:0] fall_len;
    logic [CNT_W-1:0] bot_len;
    logic [DW-1:0]    peak;
    logic [DW-1:0]    floor;
    logic             meas_done;
    logic             err;
    logic [7:0]       err_cnt;
    logic [2:0]       state;

    modport master (
        output d_in, d_valid,
        input  rise_len, top_len, fall_len, bot_len, peak, floor,
        input  meas_done, err, err_cnt, state
    );

    modport slave (
        input  d_in, d_valid,
        output rise_len, top_len, fall_len, bot_len, peak, floor,
        output meas_done, err, err_cnt, state
    );
endinterface

// File: rtl/tri_meas.sv
// Triangle-wave measurement: follows rise / top / fall / bottom segments of
// a ±1/flat sample stream and publishes segment lengths, peak and floor once
// per complete period with a one-cycle meas_done strobe. A sample breaking
// the step pattern pulses err and drops back to SYNC.
// Ports:
//   clk  - clock, rising edge
//   res  - synchronous active-high reset
//   bus  - tri_meas_if.slave: d_in/d_valid in; rise_len, top_len, fall_len,
//          bot_len, peak, floor, meas_done, err, err_cnt, state out
// Optional feature: define TRI_MEAS_ERRCNT_EN for a saturating error counter
// on err_cnt; otherwise err_cnt is constant 0.
module tri_meas #(
    parameter int unsigned DW    = 9,
    parameter int unsigned CNT_W = 10
) (
    input  logic        clk,
    input  logic        res,
    tri_meas_if.slave   bus
);
    typedef enum logic [2:0] {
        SYNC = 3'd0,
        RISE = 3'd1,
        TOP  = 3'd2,
        FALL = 3'd3,
        BOT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_n;
    logic [DW-1:0]    prev_q, prev_n;
    logic             prev_ok_q, prev_ok_n;
    logic             flat_seen_q, flat_seen_n;
    logic             arm_q, arm_n;
    logic [CNT_W-1:0] rise_cnt_q, rise_cnt_n, top_cnt_q, top_cnt_n;
    logic [CNT_W-1:0] fall_cnt_q, fall_cnt_n, bot_cnt_q, bot_cnt_n;
    logic [DW-1:0]    peak_r_q, peak_r_n, floor_r_q, floor_r_n;
    logic [CNT_W-1:0] rise_len_q, rise_len_n, top_len_q, top_len_n;
    logic [CNT_W-1:0] fall_len_q, fall_len_n, bot_len_q, bot_len_n;
    logic [DW-1:0]    peak_q, peak_n, floor_q, floor_n;
    logic             meas_done_q, meas_done_n, err_q, err_n;

    // Step classification done one bit wider so mod-2^DW wraps count as jumps
    logic [DW:0] d_x, prev_x;
    logic        is_up, is_dn, is_flat, bad;

    assign d_x     = {1'b0, bus.d_in};
    assign prev_x  = {1'b0, prev_q};
    assign is_up   = (d_x == prev_x + (DW+1)'(1));
    assign is_dn   = (d_x + (DW+1)'(1) == prev_x);
    assign is_flat = (bus.d_in == prev_q);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // State register and all datapath registers
    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= SYNC;
            prev_q      <= '0;
            prev_ok_q   <= 1'b0;
            flat_seen_q <= 1'b0;
            arm_q       <= 1'b0;
            rise_cnt_q  <= '0;
            top_cnt_q   <= '0;
            fall_cnt_q  <= '0;
            bot_cnt_q   <= '0;
            peak_r_q    <= '0;
            floor_r_q   <= '0;
            rise_len_q  <= '0;
            top_len_q   <= '0;
            fall_len_q  <= '0;
            bot_len_q   <= '0;
            peak_q      <= '0;
            floor_q     <= '0;
            meas_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_n;
            prev_q      <= prev_n;
            prev_ok_q   <= prev_ok_n;
            flat_seen_q <= flat_seen_n;
            arm_q       <= arm_n;
            rise_cnt_q  <= rise_cnt_n;
            top_cnt_q   <= top_cnt_n;
            fall_cnt_q  <= fall_cnt_n;
            bot_cnt_q   <= bot_cnt_n;
            peak_r_q    <= peak_r_n;
            floor_r_q   <= floor_r_n;
            rise_len_q  <= rise_len_n;
            top_len_q   <= top_len_n;
            fall_len_q  <= fall_len_n;
            bot_len_q   <= bot_len_n;
            peak_q      <= peak_n;
            floor_q     <= floor_n;
            meas_done_q <= meas_done_n;
            err_q       <= err_n;
        end
    end

    // Next-state and next-register logic
    always_comb begin
        state_n     = state_q;
        prev_n      = prev_q;
        prev_ok_n   = prev_ok_q;
        flat_seen_n = flat_seen_q;
        arm_n       = arm_q;
        rise_cnt_n  = rise_cnt_q;
        top_cnt_n   = top_cnt_q;
        fall_cnt_n  = fall_cnt_q;
        bot_cnt_n   = bot_cnt_q;
        peak_r_n    = peak_r_q;
        floor_r_n   = floor_r_q;
        rise_len_n  = rise_len_q;
        top_len_n   = top_len_q;
        fall_len_n  = fall_len_q;
        bot_len_n   = bot_len_q;
        peak_n      = peak_q;
        floor_n     = floor_q;
        meas_done_n = 1'b0;
        err_n       = 1'b0;
        bad         = 1'b0;

        if (bus.d_valid) begin
            prev_n    = bus.d_in;
            prev_ok_n = 1'b1;
            // The very first sample after reset only seeds prev
            if (prev_ok_q) begin
                unique case (state_q)
                    SYNC: begin
                        if (is_flat) begin
                            flat_seen_n = 1'b1;
                        end else if (is_up && flat_seen_q) begin
                            state_n    = RISE;
                            rise_cnt_n = CNT_ONE;
                            arm_n      = 1'b1;
                        end else if (is_dn && flat_seen_q) begin
                            state_n    = FALL;
                            fall_cnt_n = CNT_ONE;
                            arm_n      = 1'b0;
                        end else begin
                            flat_seen_n = 1'b0;
                        end
                    end
                    RISE: begin
                        if (is_up) begin
                            rise_cnt_n = sat_inc(rise_cnt_q);
                        end else if (is_flat) begin
                            state_n   = TOP;
                            top_cnt_n = CNT_ONE;
                            peak_r_n  = bus.d_in;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    TOP: begin
                        if (is_flat) begin
                            top_cnt_n = sat_inc(top_cnt_q);
                        end else if (is_dn) begin
                            state_n    = FALL;
                            fall_cnt_n = CNT_ONE;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    FALL: begin
                        if (is_dn) begin
                            fall_cnt_n = sat_inc(fall_cnt_q);
                        end else if (is_flat) begin
                            state_n   = BOT;
                            bot_cnt_n = CNT_ONE;
                            floor_r_n = bus.d_in;
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    BOT: begin
                        if (is_flat) begin
                            bot_cnt_n = sat_inc(bot_cnt_q);
                        end else if (is_up) begin
                            state_n    = RISE;
                            rise_cnt_n = CNT_ONE;
                            arm_n      = 1'b1;
                            // arm means this period was followed from its rise start
                            if (arm_q) begin
                                rise_len_n  = rise_cnt_q;
                                top_len_n   = top_cnt_q;
                                fall_len_n  = fall_cnt_q;
                                bot_len_n   = bot_cnt_q;
                                peak_n      = peak_r_q;
                                floor_n     = floor_r_q;
                                meas_done_n = 1'b1;
                            end
                        end else begin
                            bad = 1'b1;
                        end
                    end
                    default: state_n = SYNC;
                endcase

                if (bad) begin
                    err_n       = 1'b1;
                    state_n     = SYNC;
                    flat_seen_n = 1'b0;
                    arm_n       = 1'b0;
                    rise_cnt_n  = '0;
                    top_cnt_n   = '0;
                    fall_cnt_n  = '0;
                    bot_cnt_n   = '0;
                end
            end
        end
    end

`ifdef TRI_MEAS_ERRCNT_EN
    logic [7:0] err_cnt_q;

    // Saturating count of err pulses, updated on the same edge as err
    always_ff @(posedge clk) begin
        if (res) begin
            err_cnt_q <= '0;
        end else if (err_n && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'd0;
`endif

    assign bus.rise_len  = rise_len_q;
    assign bus.top_len   = top_len_q;
    assign bus.fall_len  = fall_len_q;
    assign bus.bot_len   = bot_len_q;
    assign bus.peak      = peak_q;
    assign bus.floor     = floor_q;
    assign bus.meas_done = meas_done_q;
    assign bus.err       = err_q;
    assign bus.state     = state_q;
endmodule

// File: tb/tb_tri_meas.sv
// Self-checking bench for tri_meas. Stimulus is built period by period
// (random levels and plateau lengths, optional d_valid gaps, injected jumps,
// a saturating plateau, a mid-fall reset and an error burst); expectations
// come from what each period is known to contain.
module tb_tri_meas;
    localparam int unsigned DW    = 9;
    localparam int unsigned CNT_W = 10;
    localparam int          SAT   = 1023;

    logic clk = 1'b0;
    logic res;
    bit   gap;
    int   n_checks, n_fail;
    int   err_total;
    int   exp_rise, exp_top, exp_fall, exp_bot, exp_peak, exp_floor;

    always #5 clk = ~clk;

    tri_meas_if #(.DW(DW), .CNT_W(CNT_W)) bus ();

    tri_meas #(.DW(DW), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_err_cnt();
`ifdef TRI_MEAS_ERRCNT_EN
        return (err_total > 255) ? 255 : err_total;
`else
        return 0;
`endif
    endfunction

    function automatic int sat(input int x);
        return (x > SAT) ? SAT : x;
    endfunction

    task automatic idle();
        bus.d_in    = DW'($urandom);
        bus.d_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle_done", 32'(bus.meas_done), 0);
        check("idle_err", 32'(bus.err), 0);
    endtask

    task automatic do_reset();
        res         = 1'b1;
        bus.d_valid = 1'b1;
        bus.d_in    = DW'($urandom);
        @(posedge clk);
        #1;
        res         = 1'b0;
        bus.d_valid = 1'b0;
        err_total   = 0;
        exp_rise = 0; exp_top = 0; exp_fall = 0; exp_bot = 0; exp_peak = 0; exp_floor = 0;
        check("rst_rise", 32'(bus.rise_len), 0);
        check("rst_top", 32'(bus.top_len), 0);
        check("rst_fall", 32'(bus.fall_len), 0);
        check("rst_bot", 32'(bus.bot_len), 0);
        check("rst_peak", 32'(bus.peak), 0);
        check("rst_floor", 32'(bus.floor), 0);
        check("rst_done", 32'(bus.meas_done), 0);
        check("rst_err", 32'(bus.err), 0);
        check("rst_errcnt", 32'(bus.err_cnt), 0);
        check("rst_state", 32'(bus.state), 0);
    endtask

    // One valid sample; xd/xe are the expected meas_done/err for it
    task automatic send(input int v, input bit xd, input bit xe);
        if (gap && ($urandom_range(1, 0) == 1)) idle();
        bus.d_in    = DW'(v);
        bus.d_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.d_valid = 1'b0;
        if (xe) err_total++;
        check("meas_done", 32'(bus.meas_done), 32'(xd));
        check("err", 32'(bus.err), 32'(xe));
        check("rise_len", 32'(bus.rise_len), exp_rise);
        check("top_len", 32'(bus.top_len), exp_top);
        check("fall_len", 32'(bus.fall_len), exp_fall);
        check("bot_len", 32'(bus.bot_len), exp_bot);
        check("peak", 32'(bus.peak), exp_peak);
        check("floor", 32'(bus.floor), exp_floor);
        check("err_cnt", 32'(bus.err_cnt), exp_err_cnt());
        if (xe) check("err_state", 32'(bus.state), 0);
        if (xd) check("pub_state", 32'(bus.state), 1);
    endtask

    // One period: lo+1..hi, hi x tl, hi-1..lo, lo x bl; optional jump of
    // +10 after lo+150 in the rise, optional stop halfway down the fall
    task automatic period(input int lo, input int hi, input int tl, input int bl,
                          input bit pub, input bit jmp, input bit cut);
        int v;
        bit e;
        v = lo + 1;
        while (v <= hi) begin
            e = 1'b0;
            if (jmp && (v == lo + 151)) begin
                v = lo + 160;
                e = 1'b1;
            end
            send(v, pub && (v == lo + 1), e);
            v++;
        end
        repeat (tl) send(hi, 1'b0, 1'b0);
        for (int x = hi - 1; x >= lo; x--) begin
            if (cut && (x < (hi + lo) / 2)) return;
            send(x, 1'b0, 1'b0);
        end
        repeat (bl) send(lo, 1'b0, 1'b0);
    endtask

    // A run of n periods from reset. A period is published at the next rise
    // start only if it was followed from its own rise start and had no jump.
    task automatic run(input int lo, input int n, input bit lead, input bit gp, input bit ideal,
                       input int jp, input int sp, input int cp, input bit burst);
        int hi, tl, bl;
        bit trk, last_ok;
        int lr, lt, lf, lb, lpk, lfl;
        lr = 0; lt = 0; lf = 0; lb = 0; lpk = 0; lfl = 0;
        gap = gp;
        do_reset();
        send(lo, 1'b0, 1'b0);
        if (lead) repeat (4) send(lo, 1'b0, 1'b0);
        trk     = lead;
        last_ok = 1'b0;
        for (int p = 0; p < n; p++) begin
            if (ideal) begin
                hi = lo + 300; tl = 201; bl = 201;
            end else begin
                hi = lo + int'($urandom_range(320, 170));
                tl = int'($urandom_range(60, 1));
                bl = int'($urandom_range(60, 1));
            end
            if (p == sp) tl = 1500;
            if (last_ok) begin
                exp_rise = lr; exp_top = lt; exp_fall = lf; exp_bot = lb;
                exp_peak = lpk; exp_floor = lfl;
            end
            period(lo, hi, tl, bl, last_ok, p == jp, p == cp);
            if (p == cp) begin
                do_reset();
                send(lo, 1'b0, 1'b0);
                trk     = 1'b0;
                last_ok = 1'b0;
            end else begin
                last_ok = trk && (p != jp);
                lr = hi - lo; lt = sat(tl); lf = hi - lo; lb = sat(bl); lpk = hi; lfl = lo;
                trk = 1'b1;
            end
        end
        if (last_ok) begin
            exp_rise = lr; exp_top = lt; exp_fall = lf; exp_bot = lb;
            exp_peak = lpk; exp_floor = lfl;
        end
        send(lo + 1, last_ok, 1'b0);
        if (burst) begin
            send(100, 1'b0, 1'b1);
            repeat (300) begin
                send(10, 1'b0, 1'b0);
                send(10, 1'b0, 1'b0);
                send(11, 1'b0, 1'b0);
                send(100, 1'b0, 1'b1);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        err_total   = 0;
        gap         = 1'b0;
        res         = 1'b0;
        bus.d_valid = 1'b0;
        bus.d_in    = '0;
        exp_rise = 0; exp_top = 0; exp_fall = 0; exp_bot = 0; exp_peak = 0; exp_floor = 0;
        repeat (2) @(posedge clk);
        #1;
        // Ideal 0..300 stream, contiguous then with gaps
        run(0, 4, 1'b0, 1'b0, 1'b1, -1, -1, -1, 1'b0);
        run(0, 4, 1'b0, 1'b1, 1'b1, -1, -1, -1, 1'b0);
        // 150 -> 160 jump in the second period's rise
        run(0, 5, 1'b0, 1'b0, 1'b1, 1, -1, -1, 1'b0);
        // Random levels with a 1500-sample top plateau in period 2
        run(int'($urandom_range(50, 0)), 4, 1'b1, 1'($urandom_range(1, 0)), 1'b0, -1, 2, -1, 1'b0);
        // Jump, mid-fall reset, clean restart, then 300 forced errors
        run(int'($urandom_range(50, 0)), 7, 1'b0, 1'b1, 1'b0, 2, -1, 3, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tri_meas.md
# tri_meas

Triangle-wave measurement block that sits at the consuming end of the triangle-wave generator's 9-bit sample bus. It tracks the rise, top-plateau, fall and bottom-plateau segments of the incoming stream with a five-state machine. At the end of each complete period it publishes the segment lengths plus the peak and floor levels, with a one-cycle done strobe. Any sample that breaks the ±1/flat step pattern is flagged and forces resynchronisation.

## Interface
- DW, 9: sample width.
- CNT_W, 10: segment length counter width; counters saturate at 2^CNT_W-1.
- clk  in  1  clock; all logic on rising edge.
- res  in  1  synchronous, active-high reset.
- d_in  in  DW  sample, equal to generator d_out.
- d_valid  in  1  sample qualifier; low means the cycle is ignored.
- rise_len  out  CNT_W  UP steps in last measured rise.
- top_len  out  CNT_W  FLAT samples in last top plateau.
- fall_len  out  CNT_W  DOWN steps in last fall.
- bot_len  out  CNT_W  FLAT samples in last bottom plateau.
- peak  out  DW  plateau level at the top.
- floor  out  DW  plateau level at the bottom.
- meas_done  out  1  one-cycle strobe; the result outputs above are new in that cycle.
- err  out  1  one-cycle strobe on a step violation.
- err_cnt  out  8  saturating error count (see Configuration).
- state  out  3  current FSM state, for debug.

## Operation
- prev register holds the last valid sample. prev_ok is cleared by reset.
- The first valid sample after reset only loads prev (prev_ok<=1). No classification happens on that sample.
- Every later valid sample is classified against prev:
  - UP: d_in==prev+1.
  - FLAT: d_in==prev.
  - DOWN: d_in==prev-1.
  - JUMP: anything else, including any mod-2^DW wrap (0→511, 511→0).
- prev<=d_in on every valid sample.
- States: SYNC=0, RISE=1, TOP=2, FALL=3, BOT=4.
- SYNC:
  - FLAT sets the flat_seen flag.
  - UP with flat_seen → RISE, rise_cnt<=1, arm<=1.
  - DOWN with flat_seen → FALL, fall_cnt<=1, arm<=0.
  - UP or DOWN without flat_seen clears flat_seen.
  - JUMP clears flat_seen and is not an error.
- RISE: UP → rise_cnt++. FLAT → TOP, top_cnt<=1, peak_r<=d_in.
- TOP: FLAT → top_cnt++. DOWN → FALL, fall_cnt<=1.
- FALL: DOWN → fall_cnt++. FLAT → BOT, bot_cnt<=1, floor_r<=d_in.
- BOT:
  - FLAT → bot_cnt++.
  - UP → RISE, rise_cnt<=1.
  - If arm=1 on that UP: copy all counters and peak_r/floor_r to the outputs and pulse meas_done.
  - arm<=1 on that UP in either case.
- Any class not listed for RISE/TOP/FALL/BOT:
  - err pulses.
  - state<=SYNC; flat_seen, arm and all counters clear.
  - The result outputs hold their last published values.
- Counters saturate at 2^CNT_W-1 and never wrap.
- d_valid=0: state, counters, prev and outputs hold; meas_done=0 and err=0.

## Timing
- Reset is synchronous and wins over every other event. The cycle after res is sampled high:
  - all outputs are 0 and state=SYNC;
  - prev_ok=0, arm=0, flat_seen=0, err_cnt=0.
- Reset mid-period discards the partial measurement.
- meas_done and err are registered and are high for exactly one cycle, in the cycle after the edge that consumed the triggering sample.
- Result outputs change only in the same cycle that meas_done is high.
- meas_done and err are never asserted together.

## Configuration
- TRI_MEAS_ERRCNT_EN defined: err_cnt increments on every err pulse and saturates at 255.
- TRI_MEAS_ERRCNT_EN undefined: err_cnt is tied to 0 and the counter logic is removed.

## Test plan
- Ideal stream with d_valid=1 from reset: ramp 0→300, 201×300, ramp 300→0, 201×0, repeated 4 periods → meas_done at the start of the 3rd rise with rise_len=300, top_len=201, fall_len=300, bot_len=201, peak=300, floor=0; err never asserted.
- Same stream with d_valid low on alternate cycles → identical results; meas_done only after valid samples.
- Jump 150→160 inside a rise → err high for 1 cycle, state=SYNC, previous results held, no meas_done until one full clean period after the next bottom plateau.
- Top plateau of 1500 samples → top_len=1023 (saturated), all other lengths correct.
- res pulsed high mid-fall → next cycle all outputs 0, state=0; measurement restarts cleanly afterwards.
- 300 forced JUMPs after a clean period → err_cnt=255 with TRI_MEAS_ERRCNT_EN defined, 0 without it.
